// File: rtl/mod_segment_serializer_pkg.sv
// Shared modulation-pipe definitions: serializer FSM states and default segment geometry.
package mod_segment_serializer_pkg;

    localparam int SEG_WIDTH = 32;
    localparam int NUM_SEG   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } seg_state_e;

endpackage

// File: rtl/mod_segment_capture_buf.sv
// Register bank holding one symbol's worth of segment words, loaded in parallel and read by index.
module mod_segment_capture_buf #(
    parameter int WIDTH   = 32,
    parameter int NUM_SEG = 8,
    parameter int IDX_W   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [NUM_SEG*WIDTH-1:0]   data_in,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [WIDTH-1:0]           rd_data
);

    logic [NUM_SEG*WIDTH-1:0] bank_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_reg <= '0;
        end else if (load) begin
            bank_reg <= data_in;
        end
    end

    assign rd_data = bank_reg[rd_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/mod_segment_serializer.sv
// Waits out the segment stages' latency after start, captures all segments at once,
// then streams them out one per valid/ready handshake, segment 0 first.
module mod_segment_serializer #(
    parameter int WIDTH     = mod_segment_serializer_pkg::SEG_WIDTH,
    parameter int NUM_SEG   = mod_segment_serializer_pkg::NUM_SEG,
    parameter int SEG_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_SEG*WIDTH-1:0] segments_in,
    input  logic                     sample_ready,
    output logic [WIDTH-1:0]         sample_out,
    output logic                     valid,
    output logic                     last,
    output logic                     busy,
    output logic                     overrun
);
    import mod_segment_serializer_pkg::*;

    localparam int                IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SEG - 1);
    localparam logic [3:0]        CNT_LOAD = 4'(SEG_DELAY - 1);

    seg_state_e         state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next, idx_inc;
    logic [WIDTH-1:0]   sample_reg, sample_next, buf_rd;
    logic               valid_reg, valid_next;
    logic               last_reg, last_next;
    logic               busy_reg, busy_next;
    logic               overrun_reg, overrun_next;
    logic               load;
    logic               transfer;

    // Reading idx+1 lets the next word be registered in the same edge as the handshake.
    assign idx_inc  = idx_reg + 1'b1;
    assign transfer = valid_reg && sample_ready;

    mod_segment_capture_buf #(
        .WIDTH   (WIDTH),
        .NUM_SEG (NUM_SEG),
        .IDX_W   (IDX_W)
    ) u_capture_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (segments_in),
        .rd_idx  (idx_inc),
        .rd_data (buf_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            sample_reg  <= sample_next;
            valid_reg   <= valid_next;
            last_reg    <= last_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        sample_next  = sample_reg;
        valid_next   = valid_reg;
        last_next    = last_reg;
        overrun_next = overrun_reg;
        load         = 1'b0;

        // A start arriving while a symbol is in flight is dropped, and remembered.
        if (start && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    load        = 1'b1;
                    idx_next    = '0;
                    state_next  = SEND;
                    valid_next  = 1'b1;
                    sample_next = segments_in[WIDTH-1:0];
                    last_next   = (NUM_SEG == 1);
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        idx_next   = '0;
                    end else begin
                        idx_next    = idx_inc;
                        sample_next = buf_rd;
                        last_next   = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign sample_out = sample_reg;
    assign valid      = valid_reg;
    assign last       = last_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_mod_segment_serializer.sv
// Directed bench for mod_segment_serializer: default build plus a SEG_DELAY=3 build.
module tb_mod_segment_serializer;

    localparam int W = 32;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, start3;
    logic             sample_ready;
    logic [N*W-1:0]   segments_in;
    logic [W-1:0]     sample_out, sample_out3;
    logic             valid, last, busy, overrun;
    logic             valid3, last3, busy3, overrun3;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_bp [11] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2,
                                 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};

    always #5 clk = ~clk;

    mod_segment_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .segments_in  (segments_in),
        .sample_ready (sample_ready),
        .sample_out   (sample_out),
        .valid        (valid),
        .last         (last),
        .busy         (busy),
        .overrun      (overrun)
    );

    mod_segment_serializer #(.SEG_DELAY(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .start        (start3),
        .segments_in  (segments_in),
        .sample_ready (sample_ready),
        .sample_out   (sample_out3),
        .valid        (valid3),
        .last         (last3),
        .busy         (busy3),
        .overrun      (overrun3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] stride);
        for (int k = 0; k < N; k++) begin
            segments_in[k*W +: W] = base + stride * k;
        end
    endtask

    // Checks eight consecutive accepted words, advancing one cycle per word.
    task automatic check_stream(input string tag, input logic [31:0] base, input logic [31:0] stride);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_valid"}, valid, 1);
            chk({tag, "_data"}, sample_out, base + stride * k);
            chk({tag, "_last"}, last, (k == N - 1));
            chk({tag, "_busy"}, busy, 1);
            $display("%s word %0d data=%h last=%b", tag, k, sample_out, last);
            step();
        end
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        start3       = 1'b0;
        sample_ready = 1'b1;
        fill(32'd0, 32'd1);
        step();
        step();

        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", sample_out, 0);
        chk("rst_valid3", valid3, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b1;
        step();
        step();

        // Basic stream
        start = 1'b1;
        chk("basic_busy_t0", busy, 0);
        step();
        start = 1'b0;
        chk("basic_busy_t1", busy, 1);
        chk("basic_valid_t1", valid, 0);
        step();
        check_stream("basic", 32'd0, 32'd1);
        chk("basic_valid_end", valid, 0);
        chk("basic_busy_end", busy, 0);
        chk("basic_last_end", last, 0);
        step();

        // Backpressure: ready low for three cycles while word 1 is presented
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int c = 0; c < 11; c++) begin
            sample_ready = !(c >= 1 && c <= 3);
            chk("bp_valid", valid, 1);
            chk("bp_data", sample_out, exp_bp[c]);
            chk("bp_last", last, (c == 10));
            $display("bp cycle %0d ready=%b data=%h last=%b", c, sample_ready, sample_out, last);
            step();
        end
        sample_ready = 1'b1;
        chk("bp_valid_end", valid, 0);
        step();

        // Capture timing: data changes right after the capture edge
        fill(32'hAAAA_AAAA, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        fill(32'h5555_5555, 32'd0);
        check_stream("capture", 32'hAAAA_AAAA, 32'd0);
        chk("capture_valid_end", valid, 0);
        chk("capture_overrun", overrun, 0);
        step();

        // Overrun: starts during SEND and on the final transfer are dropped
        fill(32'd0, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int k = 0; k < N; k++) begin
            start = (k == 3 || k == N - 1);
            chk("ovr_valid", valid, 1);
            chk("ovr_data", sample_out, k);
            chk("ovr_last", last, (k == N - 1));
            chk("ovr_flag", overrun, (k >= 4));
            $display("ovr word %0d start=%b data=%h overrun=%b", k, start, sample_out, overrun);
            step();
        end
        start = 1'b0;
        chk("ovr_valid_end", valid, 0);
        chk("ovr_busy_end", busy, 0);
        chk("ovr_flag_end", overrun, 1);
        step();
        chk("ovr_valid_after", valid, 0);
        chk("ovr_busy_after", busy, 0);
        step();

        // Reset in the middle of SEND
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("mid_valid_pre", valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_valid", valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_last", last, 0);
        chk("mid_overrun", overrun, 0);
        chk("mid_data", sample_out, 0);
        step();
        reset = 1'b1;
        step();
        chk("mid_idle_valid", valid, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_stream("rst_new", 32'd0, 32'd1);
        chk("rst_new_valid_end", valid, 0);
        step();

        // SEG_DELAY=3 build, back-to-back symbols twelve cycles apart
        fill(32'd0, 32'd1);
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            chk("d3_wait_valid", valid3, 0);
            chk("d3_wait_busy", busy3, 1);
            step();
        end
        for (int k = 0; k < N; k++) begin
            chk("d3_valid", valid3, 1);
            chk("d3_data", sample_out3, k);
            chk("d3_last", last3, (k == N - 1));
            $display("d3 sym0 word %0d data=%h last=%b", k, sample_out3, last3);
            step();
        end
        chk("d3_gap_valid", valid3, 0);
        chk("d3_gap_busy", busy3, 0);
        start3 = 1'b1;
        fill(32'h100, 32'd1);
        step();
        start3 = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            chk("d3_wait2_valid", valid3, 0);
            step();
        end
        for (int k = 0; k < N; k++) begin
            chk("d3_valid2", valid3, 1);
            chk("d3_data2", sample_out3, 32'h100 + k);
            chk("d3_last2", last3, (k == N - 1));
            $display("d3 sym1 word %0d data=%h last=%b", k, sample_out3, last3);
            step();
        end
        chk("d3_valid2_end", valid3, 0);
        chk("d3_overrun", overrun3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
